drum_voice_counter: RTL

Multi-channel sample-address sequencer for drum voices (snare, kick, hi-hat, ...). Each channel is a one-shot counter. A trigger starts it, and a shared sample-rate tick advances it. It stops at a run-time sample length latched at trigger time. The block sits between the trigger/keypad logic and the per-voice sample ROMs, and supplies the ROM addresses plus activity and done status to the mixer.

---
 rtl/drum_pkg.sv | 18 +
 rtl/drum_voice_chan.sv | 79 +++++++
 rtl/drum_voice_counter.sv | 47 ++++
 3 files changed

// File: rtl/drum_pkg.sv
// Shared types and defaults for the drum voice sequencer.
// DRUM_LOOP_EN (optional) enables per-channel looping in drum_voice_chan.
package drum_pkg;

    localparam int unsigned DEF_ADDR_W  = 15;
    localparam int unsigned DEF_MAX_LEN = 16481;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } chan_state_t;

    // Width of a packed per-channel bus (addr/len).
    function automatic int unsigned bus_w(input int unsigned nch, input int unsigned w);
        return nch * w;
    endfunction

endpackage

// File: rtl/drum_voice_chan.sv
// One drum voice: one-shot address counter with length latched at trigger.
// DRUM_LOOP_EN adds a loop input that wraps at the end instead of stopping.
module drum_voice_chan
    import drum_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned MAX_LEN = DEF_MAX_LEN
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              tick,
    input  logic              go,
    input  logic              stop_all,
`ifdef DRUM_LOOP_EN
    input  logic              loop,
`endif
    input  logic [ADDR_W-1:0] len,
    output logic [ADDR_W-1:0] addr,
    output logic              active,
    output logic              done
);

    localparam logic [ADDR_W-1:0] MAX_L = ADDR_W'(MAX_LEN);

    chan_state_t       state, state_n;
    logic [ADDR_W-1:0] lat, lat_n;
    logic [ADDR_W-1:0] addr_n;
    logic              done_n;
    logic [ADDR_W-1:0] len_clamp;
    logic              wrap;

    assign len_clamp = (len > MAX_L) ? MAX_L : len;
`ifdef DRUM_LOOP_EN
    assign wrap = loop;
`else
    assign wrap = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
            lat   <= '0;
            addr  <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            lat   <= lat_n;
            addr  <= addr_n;
            done  <= done_n;
        end
    end

    // Priority: stop_all over go over tick.
    always_comb begin
        state_n = state;
        lat_n   = lat;
        addr_n  = addr;
        done_n  = 1'b0;
        if (stop_all) begin
            state_n = ST_IDLE;
            addr_n  = '0;
        end else if (go) begin
            lat_n   = len_clamp;
            addr_n  = '0;
            state_n = (len_clamp == '0) ? ST_IDLE : ST_PLAY;
        end else if (state == ST_PLAY && tick) begin
            if (addr == lat - 1'b1) begin
                addr_n  = '0;
                done_n  = 1'b1;
                state_n = wrap ? ST_PLAY : ST_IDLE;
            end else begin
                addr_n = addr + 1'b1;
            end
        end
    end

    assign active = (state == ST_PLAY);

endmodule

// File: rtl/drum_voice_counter.sv
// Multi-channel drum sample-address sequencer; packs NUM_CH drum_voice_chan.
// DRUM_LOOP_EN adds the per-channel loop input port.
module drum_voice_counter
    import drum_pkg::*;
#(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned MAX_LEN = DEF_MAX_LEN
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic                                tick,
    input  logic [NUM_CH-1:0]                   go,
    input  logic                                stop_all,
`ifdef DRUM_LOOP_EN
    input  logic [NUM_CH-1:0]                   loop,
`endif
    input  logic [bus_w(NUM_CH, ADDR_W)-1:0]    len,
    output logic [bus_w(NUM_CH, ADDR_W)-1:0]    addr,
    output logic [NUM_CH-1:0]                   active,
    output logic [NUM_CH-1:0]                   done,
    output logic                                any_active
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        drum_voice_chan #(
            .ADDR_W  (ADDR_W),
            .MAX_LEN (MAX_LEN)
        ) u_chan (
            .clk      (clk),
            .resetn   (resetn),
            .tick     (tick),
            .go       (go[i]),
            .stop_all (stop_all),
`ifdef DRUM_LOOP_EN
            .loop     (loop[i]),
`endif
            .len      (len[i*ADDR_W +: ADDR_W]),
            .addr     (addr[i*ADDR_W +: ADDR_W]),
            .active   (active[i]),
            .done     (done[i])
        );
    end

    assign any_active = |active;

endmodule
